// File: rtl/pu_result_drain.sv
// Result drain for the matmul PU: captures packed accumulator vectors into a 2-slot buffer,
// requantises each lane (rounding shift, optional ReLU, saturation) and streams one lane per beat.
module pu_result_drain #(
  parameter int MAC_NUM      = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_WIDTH  = 5,
  parameter int LANE_W       = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            load_i,
  input  logic [OUTPUT_WIDTH*MAC_NUM-1:0] vec_i,
  input  logic [SHIFT_WIDTH-1:0]          shift_i,
  input  logic                            relu_en_i,
  input  logic                            clear_i,
  output logic [OUT_WIDTH-1:0]            out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [LANE_W-1:0]               out_lane_o,
  output logic                            out_last_o,
  output logic                            idle_o,
  output logic                            overflow_o
);

  localparam int VEC_W = OUTPUT_WIDTH * MAC_NUM;
  localparam int SUM_W = OUTPUT_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MAC_NUM - 1);

  // Handshake: a beat moves when out_valid_o && out_ready_i; while valid && !ready the
  // presented lane and data are held because both derive only from registered state.

  logic [VEC_W-1:0]       vec_q [2];
  logic [VEC_W-1:0]       vec_d [2];
  logic [SHIFT_WIDTH-1:0] shift_q [2];
  logic [SHIFT_WIDTH-1:0] shift_d [2];
  logic [1:0]             relu_q, relu_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   ovf_q, ovf_d;

  logic                   valid, last, xfer, release_slot, accept;
  logic [VEC_W-1:0]       head_vec;
  logic [SHIFT_WIDTH-1:0] head_shift;
  logic                   head_relu;
  logic signed [OUTPUT_WIDTH-1:0] lane_x;
  logic signed [SUM_W-1:0] rnd, sum, y;
  logic [OUT_WIDTH-1:0]   q_data;

  assign valid        = (count_q != 2'd0);
  assign last         = valid && (lane_q == LAST_LANE);
  assign xfer         = valid && out_ready_i;
  assign release_slot = xfer && last;
  // Free space is judged after this cycle's release so a full buffer never stalls the producer.
  assign accept       = load_i && ((count_q != 2'd2) || release_slot);

  assign head_vec   = vec_q[rd_ptr_q];
  assign head_shift = shift_q[rd_ptr_q];
  assign head_relu  = relu_q[rd_ptr_q];

  always_comb begin
    lane_x = head_vec[lane_q*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    rnd    = '0;
    sum    = {lane_x[OUTPUT_WIDTH-1], lane_x};
    y      = sum;
    q_data = '0;
    if (head_shift != '0) begin
      // One extra bit of headroom so adding the rounding constant cannot wrap.
      rnd = SUM_W'(1) << (head_shift - SHIFT_WIDTH'(1));
      sum = {lane_x[OUTPUT_WIDTH-1], lane_x} + rnd;
      y   = sum >>> head_shift;
    end
    if (head_relu && y[SUM_W-1]) y = '0;
    if (y > SAT_MAX)      q_data = SAT_MAX[OUT_WIDTH-1:0];
    else if (y < SAT_MIN) q_data = SAT_MIN[OUT_WIDTH-1:0];
    else                  q_data = y[OUT_WIDTH-1:0];
  end

  always_comb begin
    vec_d    = vec_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;

    if (xfer) lane_d = last ? '0 : lane_q + LANE_W'(1);
    if (release_slot) rd_ptr_d = ~rd_ptr_q;
    if (accept) begin
      vec_d[wr_ptr_q]   = vec_i;
      shift_d[wr_ptr_q] = shift_i;
      relu_d[wr_ptr_q]  = relu_en_i;
      wr_ptr_d          = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, accept} - {1'b0, release_slot};

    if (load_i && !accept) ovf_d = 1'b1;
    else if (clear_i)      ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 2; i++) begin
        vec_q[i]   <= '0;
        shift_q[i] <= '0;
      end
      relu_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      shift_q  <= shift_d;
      relu_q   <= relu_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid_o = valid;
  assign out_data_o  = valid ? q_data : '0;
  assign out_lane_o  = lane_q;
  assign out_last_o  = last;
  assign idle_o      = (count_q == 2'd0);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pu_result_drain.sv
// Bench for pu_result_drain: directed and random steps compared each cycle against a
// beat-queue reference model that requantises lanes with plain integer arithmetic.
module tb_pu_result_drain;

  localparam int MAC_NUM = 8;
  localparam int OW      = 32;
  localparam int OUT_W   = 8;
  localparam int SW      = 5;
  localparam int LW      = 3;

  logic                 clk = 1'b0;
  logic                 rstn_i = 1'b0;
  logic                 load_i = 1'b0;
  logic [OW*MAC_NUM-1:0] vec_i = '0;
  logic [SW-1:0]        shift_i = '0;
  logic                 relu_en_i = 1'b0;
  logic                 clear_i = 1'b0;
  logic [OUT_W-1:0]     out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b0;
  logic [LW-1:0]        out_lane_o;
  logic                 out_last_o;
  logic                 idle_o;
  logic                 overflow_o;

  int errors = 0;
  int checks = 0;

  // reference model: pending output beats in order, plus sticky overflow
  logic [OUT_W-1:0] exp_q[$];
  int               exp_lane_q[$];
  bit               m_ovf = 1'b0;

  pu_result_drain dut (
    .clk_i(clk), .rstn_i(rstn_i), .load_i(load_i), .vec_i(vec_i), .shift_i(shift_i),
    .relu_en_i(relu_en_i), .clear_i(clear_i), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_lane_o(out_lane_o),
    .out_last_o(out_last_o), .idle_o(idle_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_q(input int x, input int s, input bit relu);
    longint y;
    longint lo, hi;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    y = x;
    if (s > 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
    if (relu && y < 0) y = 0;
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y[OUT_W-1:0];
  endfunction

  function automatic logic [OW*MAC_NUM-1:0] pack8(input int a0, input int a1, input int a2,
      input int a3, input int a4, input int a5, input int a6, input int a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [OW*MAC_NUM-1:0] rand_vec();
    logic [OW*MAC_NUM-1:0] v;
    for (int k = 0; k < MAC_NUM; k++)
      v[k*OW +: OW] = $signed($urandom) >>> $urandom_range(0, 31);
    return v;
  endfunction

  // One clock: drive inputs, check presented outputs, advance the model at the edge.
  task automatic step(input bit ld, input logic [OW*MAC_NUM-1:0] v, input int s,
                      input bit r, input bit rdy, input bit clr);
    bit pop, last_pop, acc;
    int nvec;
    load_i = ld; vec_i = v; shift_i = SW'(s); relu_en_i = r;
    out_ready_i = rdy; clear_i = clr;
    #1;
    chk("valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
    chk("idle", 32'(idle_o), 32'(exp_q.size() == 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    if (exp_q.size() != 0) begin
      chk("data", 32'(out_data_o), 32'(exp_q[0]));
      chk("lane", 32'(out_lane_o), 32'(exp_lane_q[0]));
      chk("last", 32'(out_last_o), 32'(exp_lane_q[0] == MAC_NUM - 1));
    end
    @(posedge clk);
    pop      = (exp_q.size() != 0) && rdy;
    last_pop = pop && (exp_lane_q[0] == MAC_NUM - 1);
    nvec     = (exp_q.size() + MAC_NUM - 1) / MAC_NUM;
    acc      = ld && (nvec < 2 || last_pop);
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp_lane_q.pop_front());
    end
    if (acc)
      for (int k = 0; k < MAC_NUM; k++) begin
        exp_q.push_back(ref_q($signed(v[k*OW +: OW]), s, r));
        exp_lane_q.push_back(k);
      end
    if (ld && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    @(negedge clk);
    load_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; load_i = 1'b0; clear_i = 1'b0;
    @(posedge clk);
    exp_q.delete(); exp_lane_q.delete(); m_ovf = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_lane", 32'(out_lane_o), 32'd0);
    chk("rst_last", 32'(out_last_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(0, '0, 0, 0, 1, 0);
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    step(0, '0, 0, 0, 1, 0);
  endtask

  logic [OW*MAC_NUM-1:0] va, vb, vsat;
  logic [OUT_W-1:0] first_tbl [8];

  initial begin
    @(negedge clk);
    do_reset();
    step(0, '0, 0, 0, 1, 0);

    // single vector, shift 4, rounding half up; also pin the first beats to literal values
    va = pack8(56, -56, 24, 8, -8, 0, 16, -24);
    first_tbl = '{8'sd4, -8'sd3, 8'sd2, 8'sd1, 8'sd0, 8'sd0, 8'sd1, -8'sd1};
    step(1, va, 4, 0, 1, 0);
    for (int k = 0; k < MAC_NUM; k++) begin
      #1;
      chk("tbl_data", 32'(out_data_o), 32'(first_tbl[k]));
      step(0, '0, 0, 0, 1, 0);
    end
    step(0, '0, 0, 0, 1, 0);

    // saturation without and with ReLU
    vsat = pack8(10000, -10000, 127, -128, 128, -129, 0, -1);
    step(1, vsat, 0, 0, 1, 0);
    drain(20);
    step(1, vsat, 0, 1, 1, 0);
    drain(20);

    // back-to-back loads two cycles apart: 16 contiguous beats
    va = rand_vec(); vb = rand_vec();
    step(1, va, 3, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    step(1, vb, 7, 1, 1, 0);
    drain(40);

    // backpressure pattern 1,0,0,1
    va = rand_vec();
    step(1, va, 5, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, '0, 0, 0, (i % 4 == 0) || (i % 4 == 3), 0);
    drain(20);

    // overflow: third load dropped while stalled, then cleared
    step(1, rand_vec(), 2, 0, 0, 0);
    step(1, rand_vec(), 9, 1, 0, 0);
    step(1, rand_vec(), 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0);
    drain(40);

    // load at full buffer coinciding with final-lane acceptance is kept
    step(1, rand_vec(), 6, 0, 0, 0);
    step(1, rand_vec(), 31, 0, 0, 0);
    for (int i = 0; i < MAC_NUM - 1; i++) step(0, '0, 0, 0, 1, 0);
    step(1, rand_vec(), 12, 1, 1, 0);
    drain(40);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 5) == 0, rand_vec(), $urandom_range(0, 31),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    drain(40);

    // reset mid-drain at lane 3
    step(1, rand_vec(), 4, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0);
    #1;
    chk("pre_rst_lane", 32'(out_lane_o), 32'd3);
    do_reset();
    step(0, '0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_result_drain.md
Name: pu_result_drain

Overview:
- Downstream stage of the 8-lane matmul processing unit.
- Captures the unit's packed accumulator vector (MAC_NUM x 32-bit signed) when the unit signals done. Each lane is requantised: rounding arithmetic right shift, optional ReLU, saturation to OUT_WIDTH signed.
- Results stream out one lane per beat on a valid/ready interface.
- A 2-slot vector buffer lets the next result be captured while the current one drains.

Parameters:
- MAC_NUM, 8, number of lanes per captured vector
- OUTPUT_WIDTH, 32, bits per lane of the input vector (signed)
- OUT_WIDTH, 8, bits per output element (signed)
- SHIFT_WIDTH, 5, width of the shift amount

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rstn_i  input  1  synchronous, active-low reset
- load_i  input  1  single-cycle capture strobe, asserted the cycle after the PU's done
- vec_i  input  OUTPUT_WIDTH*MAC_NUM  packed signed lanes; lane k = vec_i[k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- shift_i  input  SHIFT_WIDTH  right-shift amount, sampled with load_i
- relu_en_i  input  1  ReLU enable, sampled with load_i
- clear_i  input  1  clears the sticky overflow flag
- out_data_o  output  OUT_WIDTH  requantised element (signed)
- out_valid_o  output  1  out_data_o is valid
- out_ready_i  input  1  consumer accepts the beat
- out_lane_o  output  clog2(MAC_NUM)  lane index of the current element
- out_last_o  output  1  current beat is lane MAC_NUM-1
- idle_o  output  1  both slots empty
- overflow_o  output  1  sticky: a load was dropped

Behaviour:
- Reset (rstn_i low at a clock edge) clears all state, including mid-stream. Reset values:
  - out_valid_o=0, out_data_o=0, out_lane_o=0, out_last_o=0
  - overflow_o=0, idle_o=1
  - count=0, write pointer=0, read pointer=0
- Storage:
  - 2-slot FIFO. Each slot holds the vector, shift and relu_en.
  - count ranges 0..2.
  - Separate write and read pointers, each 1 bit, toggling.
- Capture:
  - On load_i with free space, write the slot at the write pointer, toggle the pointer, count+1.
  - Free space is evaluated after the same-cycle release: load_i with count=2 coinciding with acceptance of the final lane is accepted, and count stays 2.
  - load_i with count=2 and no same-cycle release drops the vector and sets overflow_o.
- Output:
  - out_valid_o = (count != 0).
  - Data is combinational from the head slot and lane register only, so it changes only at clock edges.
  - Latency: load at edge T makes out_valid_o=1 with lane 0 in the cycle following T.
- Handshake:
  - A beat transfers when out_valid_o && out_ready_i.
  - Data and lane are held stable while valid && !ready.
  - Each transfer increments the lane.
  - Transfer with out_last_o=1: lane returns to 0, the slot is released (read pointer toggles, count-1). If the other slot is full, its lane 0 is presented the next cycle with no bubble.
  - Full-rate throughput: 1 element per cycle when ready is held high.
- Requantisation per lane, with x the 32-bit signed lane:
  - s=0: y=x.
  - s>0: y=(x + 2^(s-1)) >>> s, computed at 33 bits so rounding cannot overflow (round half up).
  - If relu_en and y<0: y=0.
  - Saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Overflow flag:
  - overflow_o stays set until clear_i or reset.
  - clear_i and a dropped load in the same cycle leave overflow_o=1 (set wins).
- idle_o = (count==0).

Test Plan:
- Single vector, shift=4, relu=0, lanes {56,-56,24,8,-8,0,16,-24}, ready=1 -> 8 beats on consecutive cycles starting the cycle after load: {4,-3,2,1,0,0,1,-1}; out_last_o on beat 8; idle_o=1 afterwards.
- Saturation, shift=0: lanes {10000,-10000,127,-128,...} with relu=0 -> {127,-128,127,-128}; the same vector with relu=1 -> {127,0,127,0}.
- Back-to-back loads (vector A, then vector B 2 cycles later), ready=1 -> 16 contiguous beats, no bubble between A lane 7 and B lane 0; overflow_o=0.
- Backpressure: ready toggles 1,0,0,1 per cycle -> data and lane stable during stalls; each lane appears exactly once, in order.
- Overflow: with ready=0, three loads -> first two retained, third dropped, overflow_o=1. Then clear_i -> overflow_o=0. Releasing ready drains exactly the first two vectors.
- Boundaries:
  - Load at count=2 in the same cycle as final-lane acceptance -> accepted, overflow_o stays 0.
  - rstn_i=0 mid-drain (lane 3) -> next cycle out_valid_o=0, out_lane_o=0, idle_o=1.
